// File: rtl/dds_pkg.sv
// Shared definitions for the DDS block: mode encodings, sweep FSM states and
// default word widths used by both the sweep controller and the DDS core.
package dds_pkg;

   localparam int DDS_FW_W    = 32;
   localparam int DDS_DWELL_W = 16;

   localparam logic [1:0] DDS_MODE_SINGLE     = 2'd0;
   localparam logic [1:0] DDS_MODE_SAW        = 2'd1;
   localparam logic [1:0] DDS_MODE_TRI        = 2'd2;
   localparam logic [1:0] DDS_MODE_SINGLE_ALT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_STEP  = 2'd2,
      ST_FIN   = 2'd3
   } dds_state_e;

endpackage

// File: rtl/dds_sweep_step.sv
// Combinational saturating step: moves the current word one step toward the
// leg endpoint, clamping so the result never passes the endpoint or wraps.
module dds_sweep_step
   import dds_pkg::*;
#(
   parameter int FW_W = DDS_FW_W
) (
   input  logic [FW_W-1:0] cur_fw,
   input  logic [FW_W-1:0] step_fw,
   input  logic [FW_W-1:0] end_fw,
   input  logic            dir_down,
   output logic [FW_W-1:0] next_fw,
   output logic            at_end
);

   logic [FW_W:0] w_sum;
   logic [FW_W:0] w_dif;
   logic [FW_W:0] w_end_x;
   logic          w_over;

   assign w_sum   = {1'b0, cur_fw} + {1'b0, step_fw};
   assign w_dif   = {1'b0, cur_fw} - {1'b0, step_fw};
   assign w_end_x = {1'b0, end_fw};

   // The extra top bit carries out of the add and borrows out of the subtract,
   // so a step past 0 or past all-ones is still seen as an overshoot.
   always_comb begin
      w_over = 1'b0;
      if (dir_down) begin
         w_over = w_dif[FW_W] || (w_dif < w_end_x);
      end else begin
         w_over = (w_sum > w_end_x);
      end
   end

   always_comb begin
      next_fw = end_fw;
      if (!w_over) begin
         next_fw = dir_down ? w_dif[FW_W-1:0] : w_sum[FW_W-1:0];
      end
   end

   assign at_end = (cur_fw == end_fw);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS core: latches a sweep programme on
// start and walks freq_word from start to stop with a per-word dwell.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int FW_W    = DDS_FW_W,
   parameter int DWELL_W = DDS_DWELL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FW_W-1:0]    cfg_start_fw,
   input  logic [FW_W-1:0]    cfg_stop_fw,
   input  logic [FW_W-1:0]    cfg_step_fw,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               start,
   input  logic               abort,
   output logic [FW_W-1:0]    freq_word,
   output logic               phase_clr,
   output logic               busy,
   output logic               done,
   output logic               dir_down
);

   dds_state_e         r_state;
   logic [FW_W-1:0]    r_fw;
   logic               r_pclr;
   logic               r_busy;
   logic               r_done;
   logic               r_dir;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_leg_back;

   logic [FW_W-1:0]    r_start_fw;
   logic [FW_W-1:0]    r_stop_fw;
   logic [FW_W-1:0]    r_step_fw;
   logic [DWELL_W-1:0] r_dwell;
   logic [1:0]         r_mode;
   logic               r_degen;

   dds_state_e         w_state_nxt;
   logic [FW_W-1:0]    w_fw_nxt;
   logic               w_pclr_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_dir_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic               w_leg_nxt;
   logic               w_load;

   logic [FW_W-1:0]    w_end_fw;
   logic [FW_W-1:0]    w_step_fw;
   logic               w_at_end;

   // A leg runs toward stop, or back toward start on the return leg of a triangle.
   assign w_end_fw = r_leg_back ? r_start_fw : r_stop_fw;

   dds_sweep_step #(
      .FW_W(FW_W)
   ) u_step (
      .cur_fw  (r_fw),
      .step_fw (r_step_fw),
      .end_fw  (w_end_fw),
      .dir_down(r_dir),
      .next_fw (w_step_fw),
      .at_end  (w_at_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_fw <= '0;
         r_stop_fw  <= '0;
         r_step_fw  <= '0;
         r_dwell    <= '0;
         r_mode     <= DDS_MODE_SINGLE;
         r_degen    <= 1'b0;
      end else if (w_load) begin
         r_start_fw <= cfg_start_fw;
         r_stop_fw  <= cfg_stop_fw;
         r_step_fw  <= cfg_step_fw;
         r_dwell    <= cfg_dwell;
         r_mode     <= cfg_mode;
         r_degen    <= (cfg_step_fw == '0) || (cfg_start_fw == cfg_stop_fw);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_fw       <= '0;
         r_pclr     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dir      <= 1'b0;
         r_cnt      <= '0;
         r_leg_back <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fw       <= w_fw_nxt;
         r_pclr     <= w_pclr_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_dir      <= w_dir_nxt;
         r_cnt      <= w_cnt_nxt;
         r_leg_back <= w_leg_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fw_nxt    = r_fw;
      w_pclr_nxt  = 1'b0;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      w_leg_nxt   = r_leg_back;
      w_load      = 1'b0;

      if (abort && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
         w_fw_nxt    = '0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_fw_nxt   = '0;
               w_busy_nxt = 1'b0;
               if (start && !abort) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_DWELL;
                  w_fw_nxt    = cfg_start_fw;
                  w_pclr_nxt  = 1'b1;
                  w_busy_nxt  = 1'b1;
                  w_cnt_nxt   = cfg_dwell;
                  w_dir_nxt   = (cfg_stop_fw < cfg_start_fw);
                  w_leg_nxt   = 1'b0;
               end
            end

            ST_DWELL: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end else if (!(r_degen || w_at_end)) begin
                  w_state_nxt = ST_STEP;
               end else begin
                  // Endpoint reached (or a single-word sweep): the mode decides.
                  case (r_mode)
                     DDS_MODE_SAW: begin
                        w_cnt_nxt = r_dwell;
                        if (!r_degen) begin
                           w_fw_nxt   = r_start_fw;
                           w_pclr_nxt = 1'b1;
                        end
                     end
                     DDS_MODE_TRI: begin
                        if (r_degen) begin
                           w_cnt_nxt = r_dwell;
                        end else begin
                           w_dir_nxt   = ~r_dir;
                           w_leg_nxt   = ~r_leg_back;
                           w_state_nxt = ST_STEP;
                        end
                     end
                     DDS_MODE_SINGLE, DDS_MODE_SINGLE_ALT: begin
                        w_state_nxt = ST_FIN;
                        w_done_nxt  = 1'b1;
                     end
                  endcase
               end
            end

            ST_STEP: begin
               w_fw_nxt    = w_step_fw;
               w_cnt_nxt   = r_dwell;
               w_state_nxt = ST_DWELL;
            end

            ST_FIN: begin
               w_state_nxt = ST_IDLE;
               w_fw_nxt    = '0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign freq_word = r_fw;
   assign phase_clr = r_pclr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dir_down  = r_dir;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweep programmes
// compared cycle by cycle against an expected-trace model built from the sweep rules.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cfg_start_fw, cfg_stop_fw, cfg_step_fw;
   logic [15:0] cfg_dwell;
   logic [1:0]  cfg_mode;
   logic        start, abort;
   logic [31:0] freq_word;
   logic        phase_clr, busy, done, dir_down;

   int checks = 0;
   int errors = 0;

   longint q_fw[$];
   bit     q_pc[$], q_done[$], q_busy[$], q_dn[$];
   longint obs_fw[$];

   dds_sweep_ctrl #(.FW_W(32), .DWELL_W(16)) dut (
      .clk(clk), .rst(rst),
      .cfg_start_fw(cfg_start_fw), .cfg_stop_fw(cfg_stop_fw),
      .cfg_step_fw(cfg_step_fw), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
      .start(start), .abort(abort),
      .freq_word(freq_word), .phase_clr(phase_clr), .busy(busy),
      .done(done), .dir_down(dir_down)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint nstep(longint cur, longint st, longint tgt, bit dn);
      longint n;
      if (dn) begin
         n = cur - st;
         if (n < tgt) n = tgt;
      end else begin
         n = cur + st;
         if (n > tgt) n = tgt;
      end
      return n;
   endfunction

   task automatic push(input longint fw, input bit pc, input bit dn_, input bit bz, input bit dn);
      q_fw.push_back(fw); q_pc.push_back(pc); q_done.push_back(dn_);
      q_busy.push_back(bz); q_dn.push_back(dn);
   endtask

   task automatic emit(input int n, input longint fw, input bit first, input bit dn);
      for (int i = 0; i < n; i++) push(fw, first && (i == 0), 1'b0, 1'b1, dn);
   endtask

   // Expected per-cycle trace starting with the cycle after start is accepted.
   task automatic build(input longint s, input longint e, input longint st,
                        input int dw, input int md, input int maxc);
      longint cur, tgt;
      bit dn, degen, first;
      q_fw.delete(); q_pc.delete(); q_done.delete(); q_busy.delete(); q_dn.delete();
      dn = (e < s); degen = (st == 0) || (s == e);
      cur = s; tgt = e; first = 1'b1;
      if (md == 0 || md == 3) begin
         while (1) begin
            if (degen || cur == e) begin
               emit(dw + 1, cur, first, dn);
               push(cur, 1'b0, 1'b1, 1'b1, dn);
               push(0, 1'b0, 1'b0, 1'b0, dn);
               break;
            end
            emit(dw + 2, cur, first, dn);
            first = 1'b0;
            cur = nstep(cur, st, e, dn);
         end
      end else if (md == 1) begin
         while (q_fw.size() < maxc) begin
            if (degen) begin
               emit(dw + 1, cur, first, dn); first = 1'b0;
            end else if (cur == e) begin
               emit(dw + 1, cur, first, dn);
               cur = s; first = 1'b1;
            end else begin
               emit(dw + 2, cur, first, dn);
               first = 1'b0;
               cur = nstep(cur, st, e, dn);
            end
         end
      end else begin
         while (q_fw.size() < maxc) begin
            if (degen) begin
               emit(dw + 1, cur, first, dn); first = 1'b0;
            end else begin
               emit(dw + 1, cur, first, dn); first = 1'b0;
               if (cur == tgt) begin
                  tgt = (tgt == e) ? s : e;
                  dn = !dn;
               end
               emit(1, cur, 1'b0, dn);
               cur = nstep(cur, st, tgt, dn);
            end
         end
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " fw"}, {32'd0, freq_word}, 64'd0);
      chk({tag, " busy"}, {63'd0, busy}, 64'd0);
      chk({tag, " done"}, {63'd0, done}, 64'd0);
      chk({tag, " pclr"}, {63'd0, phase_clr}, 64'd0);
   endtask

   task automatic run(input string name, input longint s, input longint e, input longint st,
                      input int dw, input int md, input int maxc, input int abort_k,
                      input bit chaos);
      int len;
      build(s, e, st, dw, md, maxc);
      len = (abort_k >= 0) ? abort_k + 1 : q_fw.size();
      obs_fw.delete();
      @(negedge clk);
      cfg_start_fw = s[31:0]; cfg_stop_fw = e[31:0]; cfg_step_fw = st[31:0];
      cfg_dwell = dw[15:0]; cfg_mode = md[1:0];
      start = 1'b1; abort = 1'b0;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         start = 1'b0;
         obs_fw.push_back(longint'(freq_word));
         chk($sformatf("%s fw[%0d]", name, k), {32'd0, freq_word}, q_fw[k]);
         chk($sformatf("%s pclr[%0d]", name, k), {63'd0, phase_clr}, {63'd0, q_pc[k]});
         chk($sformatf("%s done[%0d]", name, k), {63'd0, done}, {63'd0, q_done[k]});
         chk($sformatf("%s busy[%0d]", name, k), {63'd0, busy}, {63'd0, q_busy[k]});
         if (q_busy[k])
            chk($sformatf("%s dir[%0d]", name, k), {63'd0, dir_down}, {63'd0, q_dn[k]});
         if (chaos) begin
            cfg_start_fw = $urandom(); cfg_stop_fw = $urandom();
            cfg_step_fw = $urandom(); cfg_dwell = 16'($urandom_range(0, 9));
            cfg_mode = 2'($urandom_range(0, 3));
            if (q_busy[k] && $urandom_range(0, 3) == 0) start = 1'b1;
         end
         if (k == abort_k) abort = 1'b1;
      end
      if (abort_k >= 0) begin
         @(negedge clk);
         abort = 1'b0;
         chk_idle({name, " post-abort"});
      end
      start = 1'b0;
   endtask

   initial begin
      longint single_up[13];
      longint rs, re, rst_step;
      int rdw, rmd, rmax;

      single_up = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130, 0};
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_start_fw = '0; cfg_stop_fw = '0; cfg_step_fw = '0; cfg_dwell = '0; cfg_mode = '0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      chk("reset dir", {63'd0, dir_down}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("after reset");

      run("single_up", 100, 130, 10, 1, 0, 0, -1, 1'b0);
      for (int i = 0; i < 13; i++)
         chk($sformatf("single_up table[%0d]", i), obs_fw[i], single_up[i]);

      run("clamp_down", 50, 5, 20, 0, 3, 0, -1, 1'b0);
      run("saw", 0, 2, 1, 0, 1, 12, 11, 1'b0);
      run("tri", 0, 4, 2, 0, 2, 20, 19, 1'b0);
      run("top_sat", 64'hFFFF_FFFD, 64'hFFFF_FFFF, 5, 2, 0, 0, -1, 1'b0);
      run("tri_top", 64'hFFFF_FFF0, 64'hFFFF_FFFF, 7, 0, 2, 24, 23, 1'b0);
      run("saw_down_zero", 9, 0, 4, 1, 1, 30, 29, 1'b0);
      run("abort_dwell", 100, 200, 10, 5, 0, 0, 3, 1'b0);
      run("busy_start", 300, 260, 9, 2, 0, 0, -1, 1'b1);
      run("zero_step", 7, 900, 0, 2, 0, 0, -1, 1'b0);
      run("zero_step_saw", 7, 900, 0, 1, 1, 10, 9, 1'b0);
      run("flat_tri", 40, 40, 3, 1, 2, 10, 9, 1'b0);

      // abort and start together in IDLE: start must be dropped
      @(negedge clk);
      cfg_start_fw = 32'd55; cfg_stop_fw = 32'd99; cfg_step_fw = 32'd1; cfg_mode = 2'd0;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk_idle("abort_start_idle");

      for (int r = 0; r < 12; r++) begin
         rs = $urandom_range(0, 200); re = $urandom_range(0, 200);
         rst_step = $urandom_range(0, 40); rdw = $urandom_range(0, 3);
         rmd = $urandom_range(0, 3); rmax = $urandom_range(10, 60);
         if (rmd == 1 || rmd == 2)
            run($sformatf("rand%0d", r), rs, re, rst_step, rdw, rmd, rmax, rmax - 1, 1'b1);
         else
            run($sformatf("rand%0d", r), rs, re, rst_step, rdw, rmd, 0, -1, 1'b1);
      end

      @(negedge clk);
      chk_idle("final idle");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler that sequences the DDS core's frequency word. It latches a start/stop/step/dwell sweep programme on a start request. It then steps the frequency word linearly toward the stop value, holding each value for a programmable dwell. Single-shot, sawtooth-repeat and triangle modes are supported. The block sits between the control/register interface and the `freq_word` input of the DDS phase accumulator, and owns the phase-clear strobe for that core.

## Interface
Parameters:
- `FW_W`, 32: frequency-word width (matches the DDS accumulator increment).
- `DWELL_W`, 16: dwell counter width.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_start_fw`  in  FW_W: first frequency word, unsigned.
- `cfg_stop_fw`  in  FW_W: final frequency word, unsigned.
- `cfg_step_fw`  in  FW_W: step magnitude, unsigned.
- `cfg_dwell`  in  DWELL_W: each word is held for `cfg_dwell+1` cycles.
- `cfg_mode`  in  2: 0 = single, 1 = sawtooth repeat, 2 = triangle repeat, 3 = single.
- `start`  in  1: request pulse; accepted only in IDLE.
- `abort`  in  1: stops any sweep; highest priority after `rst`.
- `freq_word`  out  FW_W: drives the DDS core increment.
- `phase_clr`  out  1: one-cycle pulse that clears the DDS accumulator.
- `busy`  out  1: high from the cycle after `start` is accepted until return to IDLE.
- `done`  out  1: one-cycle pulse at single-sweep completion.
- `dir_down`  out  1: current sweep direction (1 = decreasing).

## Operation
- States: IDLE, DWELL, STEP, FIN.
- **IDLE**
  - `freq_word`=0 and `busy`=0.
  - On `start`, latch all `cfg_*` inputs, load `freq_word`←start, pulse `phase_clr`, load the dwell counter with `cfg_dwell`, and go to DWELL.
  - Base direction is `dir_down` = (stop < start).
- **DWELL**
  - Decrement the counter each cycle.
  - At 0, go to STEP, or go to FIN if the current word already equals the endpoint of the leg in single mode.
- **STEP** (one cycle; `freq_word` holds its value during it). Next word = current ± step, saturated at the leg endpoint.
  - The saturation compare uses the FW_W+1-bit sum/difference, so there is no overshoot and no wrap past 0 or 2^FW_W−1.
  - Reload dwell and return to DWELL.
- **Endpoint reached, then the dwell expires:**
  - single: go to FIN.
  - sawtooth: `freq_word`←start, pulse `phase_clr`, return to DWELL.
  - triangle: invert `dir_down`, swap the leg endpoint between start and stop, and take a normal STEP. No `phase_clr`.
- **FIN**
  - Pulse `done` for one cycle.
  - Hold `freq_word` at the stop value for that cycle, then return to IDLE with `freq_word`=0.
- **Degenerate cases**
  - `cfg_step_fw`=0, or start==stop: the sweep is the single word start. single mode finishes after one dwell. Repeat modes hold start indefinitely, dwelling without any `phase_clr` re-pulse, until `abort`.
- **abort** in any non-IDLE state: next cycle is IDLE, `freq_word`=0, and no `done`. An `abort` and `start` in the same IDLE cycle means `start` is ignored.
- `start` while busy is ignored, and the latched configuration is unaffected. `cfg_*` changes mid-sweep have no effect.

## Timing
- Reset values: `freq_word`=0, `phase_clr`=0, `busy`=0, `done`=0, `dir_down`=0; state IDLE.
- All outputs are registered.
- `start` sampled in cycle T gives:
  - `freq_word`=start and `phase_clr`=1 at T+1;
  - `busy`=1 from T+1.
- Each intermediate word is held for `cfg_dwell`+2 cycles: `cfg_dwell`+1 dwell cycles plus the STEP cycle.
- The final word is held for `cfg_dwell`+1 cycles, plus 1 FIN cycle in single mode.
- `done` occurs in the FIN cycle, and `busy` falls in the cycle after FIN.
- The DDS core sees each new `freq_word` on the edge after it changes. `phase_clr` is coincident with the first word of each sweep.

## Structure
- Shared package `dds_pkg`:
  - mode encodings `DDS_MODE_SINGLE`/`SAW`/`TRI`;
  - state enum;
  - default `FW_W`/`DWELL_W` constants reused by the DDS core.
- One natural sub-module, `dds_sweep_step`: a combinational saturating step unit (inputs: current word, step, endpoint, `dir_down`; outputs: next word, `at_end`). The FSM and dwell counter stay in the top module.

## Test plan
- Single up sweep: start=100, stop=130, step=10, dwell=1.
  - `freq_word` sequence: 100,100,100,110,110,110,120,120,120,130,130,130(FIN) → 0.
  - `phase_clr` once at T+1; `done` pulses once; `busy` is low the cycle after.
- Overshoot clamp, down: start=50, stop=5, step=20, dwell=0.
  - Words 50,30,10,5; `dir_down`=1; no value below 5.
- Sawtooth: start=0, stop=2, step=1, dwell=0, run 12 cycles.
  - Repeating 0,0,1,1,2 pattern; `phase_clr` on every return to 0; `done` never asserted.
- Triangle: start=0, stop=4, step=2, dwell=0.
  - 0,2,4,2,0,2,…; `dir_down` toggles at 4 and 0; no `phase_clr` after the first.
- Saturation at the top: start=2^32−3, stop=2^32−1, step=5.
  - Words 2^32−3 then 2^32−1; no wrap to a small value.
- Abort and start handling:
  - `abort` mid-DWELL gives `freq_word`=0 and `busy`=0 next cycle, with no `done`.
  - `start` during `busy` is ignored.
  - Zero-step single mode finishes after one dwell.
